// File: rtl/ex_mem_skid_reg_if.sv
// EX->MEM beat bundle: valid/ready handshake plus the ALU result and MEM/WB control payload.
// The producer side uses the master modport and the consumer side uses the slave modport.
// Carries no logic; the parameters must match those of the skid register that uses it.
interface ex_mem_skid_reg_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              valid;
  logic              ready;
  logic [XLEN-1:0]   alu_result;
  logic              alu_zero;
  logic [XLEN-1:0]   write_data;
  logic [XLEN-1:0]   pc_target;
  logic [REG_AW-1:0] rd_addr;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic              branch;
  logic [2:0]        funct3;

  // Producer: drives the beat and observes ready.
  modport master (
    output valid, alu_result, alu_zero, write_data, pc_target,
           rd_addr, reg_write, mem_read, mem_write, branch, funct3,
    input  ready
  );

  // Consumer: observes the beat and drives ready.
  modport slave (
    input  valid, alu_result, alu_zero, write_data, pc_target,
           rd_addr, reg_write, mem_read, mem_write, branch, funct3,
    output ready
  );
endinterface

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register: a two-entry skid buffer that also resolves the branch decision.
// Latency is 1 cycle from accept to out_valid, and throughput is one beat per cycle.
// in_ready is registered (= !skid_valid), so a MEM stall never reaches EX combinationally.
// Optional macro PERF_CNT_EN builds a saturating stall counter; without it, stall_cycles_o is 0.
module ex_mem_skid_reg #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  ex_mem_skid_reg_if.slave   in_if,
  ex_mem_skid_reg_if.master  out_if,
  output logic               out_br_taken_o,
  output logic [CNT_W-1:0]   stall_cycles_o
);

  typedef struct packed {
    logic [XLEN-1:0]   alu_result;
    logic              alu_zero;
    logic [XLEN-1:0]   write_data;
    logic [XLEN-1:0]   pc_target;
    logic [REG_AW-1:0] rd_addr;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic [2:0]        funct3;
    logic              br_taken;
  } beat_t;

  beat_t main_q, main_d;
  beat_t skid_q, skid_d;
  logic  main_vld_q, main_vld_d;
  logic  skid_vld_q, skid_vld_d;
  beat_t in_beat;
  logic  br_taken;
  logic  accept;
  logic  pop;

  // Branch condition from ALU flags; LT/LTU variants rely on the ALU running SLT/SLTU.
  always_comb begin
    br_taken = 1'b0;
    if (in_if.branch) begin
      case (in_if.funct3)
        3'b000:          br_taken = in_if.alu_zero;
        3'b001:          br_taken = ~in_if.alu_zero;
        3'b100, 3'b110:  br_taken = in_if.alu_result[0];
        3'b101, 3'b111:  br_taken = ~in_if.alu_result[0];
        default:         br_taken = 1'b0;
      endcase
    end
  end

  // Pack the incoming fields and the resolved decision into one beat.
  always_comb begin
    in_beat            = '0;
    in_beat.alu_result = in_if.alu_result;
    in_beat.alu_zero   = in_if.alu_zero;
    in_beat.write_data = in_if.write_data;
    in_beat.pc_target  = in_if.pc_target;
    in_beat.rd_addr    = in_if.rd_addr;
    in_beat.reg_write  = in_if.reg_write;
    in_beat.mem_read   = in_if.mem_read;
    in_beat.mem_write  = in_if.mem_write;
    in_beat.branch     = in_if.branch;
    in_beat.funct3     = in_if.funct3;
    in_beat.br_taken   = br_taken;
  end

  // in_ready is !skid_vld_q, so accept never depends on out_ready.
  assign accept = in_if.valid & ~skid_vld_q;
  assign pop    = main_vld_q & out_if.ready;

  // Next-state logic: the main slot feeds the output and the skid slot absorbs one stalled beat.
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush_i) begin
      // Both held beats and any incoming beat are dropped; the payload may keep stale values.
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      case ({main_vld_q, skid_vld_q})
        2'b00: begin
          if (accept) begin
            main_d     = in_beat;
            main_vld_d = 1'b1;
          end
        end
        2'b10: begin
          if (accept && pop) begin
            main_d = in_beat;
          end else if (accept) begin
            // The output is stalled, so park the new beat behind it.
            skid_d     = in_beat;
            skid_vld_d = 1'b1;
          end else if (pop) begin
            main_vld_d = 1'b0;
          end
        end
        2'b11: begin
          if (pop) begin
            main_d     = skid_q;
            skid_vld_d = 1'b0;
          end
        end
        default: begin
          // The skid slot is never occupied on its own; recover to empty.
          main_vld_d = 1'b0;
          skid_vld_d = 1'b0;
        end
      endcase
    end
  end

  // State and payload registers; synchronous reset clears everything, including the payload.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign in_if.ready        = ~skid_vld_q;
  assign out_if.valid       = main_vld_q;
  assign out_if.alu_result  = main_q.alu_result;
  assign out_if.alu_zero    = main_q.alu_zero;
  assign out_if.write_data  = main_q.write_data;
  assign out_if.pc_target   = main_q.pc_target;
  assign out_if.rd_addr     = main_q.rd_addr;
  assign out_if.reg_write   = main_q.reg_write;
  assign out_if.mem_read    = main_q.mem_read;
  assign out_if.mem_write   = main_q.mem_write;
  assign out_if.branch      = main_q.branch;
  assign out_if.funct3      = main_q.funct3;
  assign out_br_taken_o     = main_q.br_taken;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  // Count cycles where MEM holds off a valid beat; the counter saturates and ignores flush.
  always_comb begin
    stall_d = stall_q;
    if (main_vld_q && !out_if.ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // The stall counter is cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Bench for ex_mem_skid_reg: directed literal checks plus a randomized run against a queue model.
module tb_ex_mem_skid_reg;

  typedef struct packed {
    logic [31:0] alu;
    logic        z;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic [2:0]  f3;
  } beat_t;

  typedef struct {
    beat_t b;
    logic  t;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        out_br;
  logic [31:0] stall;

  int total = 0;
  int bad   = 0;

  ex_mem_skid_reg_if #(.XLEN(32), .REG_AW(5)) in_if ();
  ex_mem_skid_reg_if #(.XLEN(32), .REG_AW(5)) out_if ();

  ex_mem_skid_reg #(.XLEN(32), .REG_AW(5), .CNT_W(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .in_if          (in_if),
    .out_if         (out_if),
    .out_br_taken_o (out_br),
    .stall_cycles_o (stall)
  );

  always #5 clk = ~clk;

  // Reference model: the buffer is a FIFO holding at most two beats.
  ent_t    q[$];
  longint  exp_stall = 0;
  bit      started = 0;

  function automatic logic taken(input beat_t b);
    if (!b.br) return 1'b0;
    case (b.f3)
      3'd0:       return b.z;
      3'd1:       return !b.z;
      3'd4, 3'd6: return b.alu[0];
      3'd5, 3'd7: return !b.alu[0];
      default:    return 1'b0;
    endcase
  endfunction

  function automatic beat_t in_beat();
    return {in_if.alu_result, in_if.alu_zero, in_if.write_data, in_if.pc_target,
            in_if.rd_addr, in_if.reg_write, in_if.mem_read, in_if.mem_write,
            in_if.branch, in_if.funct3};
  endfunction

  function automatic beat_t out_beat();
    return {out_if.alu_result, out_if.alu_zero, out_if.write_data, out_if.pc_target,
            out_if.rd_addr, out_if.reg_write, out_if.mem_read, out_if.mem_write,
            out_if.branch, out_if.funct3};
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    b.alu = $urandom;
    b.z   = 1'($urandom_range(0, 1));
    b.wd  = $urandom;
    b.pc  = $urandom;
    b.rd  = 5'($urandom_range(0, 31));
    b.rw  = 1'($urandom_range(0, 1));
    b.mr  = 1'($urandom_range(0, 1));
    b.mw  = 1'($urandom_range(0, 1));
    b.br  = 1'($urandom_range(0, 1));
    b.f3  = 3'($urandom_range(0, 7));
    return b;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic put(input beat_t b, input logic v);
    in_if.valid      = v;
    in_if.alu_result = b.alu;
    in_if.alu_zero   = b.z;
    in_if.write_data = b.wd;
    in_if.pc_target  = b.pc;
    in_if.rd_addr    = b.rd;
    in_if.reg_write  = b.rw;
    in_if.mem_read   = b.mr;
    in_if.mem_write  = b.mw;
    in_if.branch     = b.br;
    in_if.funct3     = b.f3;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Model update at each active edge from the inputs that the edge samples.
  always @(posedge clk) begin
    ent_t e;
    bit   do_pop, do_acc;
    if (!rst_n) begin
      q.delete();
      exp_stall = 0;
    end else begin
      if (q.size() > 0 && !out_if.ready && exp_stall < 64'hFFFF_FFFF) exp_stall++;
      if (flush) begin
        q.delete();
      end else begin
        do_pop = (q.size() > 0) && out_if.ready;
        do_acc = in_if.valid && (q.size() < 2);
        if (do_pop) void'(q.pop_front());
        if (do_acc) begin
          e.b = in_beat();
          e.t = taken(e.b);
          q.push_back(e);
        end
      end
    end
    started = 1;
  end

  // Every-cycle comparison of the DUT outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 128'(out_if.valid), 128'(q.size() > 0));
      chk("in_ready", 128'(in_if.ready), 128'(q.size() < 2));
`ifdef PERF_CNT_EN
      chk("stall_cycles", 128'(stall), 128'(exp_stall));
`else
      chk("stall_cycles", 128'(stall), 128'(0));
`endif
      if (q.size() > 0) begin
        chk("payload", 128'(out_beat()), 128'(q[0].b));
        chk("br_taken", 128'(out_br), 128'(q[0].t));
      end
    end
  end

  typedef struct {
    logic       br;
    logic [2:0] f3;
    logic       z;
    logic [31:0] alu;
    logic       exp;
  } brv_t;

  initial begin
    beat_t b;
    brv_t  bt[4];
    bt[0] = '{1'b1, 3'b000, 1'b1, 32'd0, 1'b1};
    bt[1] = '{1'b1, 3'b101, 1'b0, 32'd1, 1'b0};
    bt[2] = '{1'b1, 3'b110, 1'b0, 32'd1, 1'b1};
    bt[3] = '{1'b0, 3'b000, 1'b1, 32'd0, 1'b0};

    // Reset held for two cycles with a beat offered.
    rst_n = 1'b0;
    flush = 1'b0;
    out_if.ready = 1'b0;
    put(rnd_beat(), 1'b1);
    tick();
    tick();
    chk("rst out_valid", 128'(out_if.valid), 128'(0));
    chk("rst in_ready", 128'(in_if.ready), 128'(1));
    chk("rst payload", 128'(out_beat()), 128'(0));
    chk("rst br_taken", 128'(out_br), 128'(0));
    chk("rst stall", 128'(stall), 128'(0));
    rst_n = 1'b1;
    put('0, 1'b0);
    tick();

    // Stream of eight beats with the output always ready.
    out_if.ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      b = '0;
      b.alu = 32'(k);
      put(b, 1'b1);
      tick();
      chk("stream value", 128'(out_if.alu_result), 128'(k));
      chk("stream valid", 128'(out_if.valid), 128'(1));
      chk("stream in_ready", 128'(in_if.ready), 128'(1));
    end
    put('0, 1'b0);
    tick();
    chk("stream drained", 128'(out_if.valid), 128'(0));

    // Backpressure fills the skid slot and then drains it.
    out_if.ready = 1'b0;
    b = '0; b.alu = 32'hA; put(b, 1'b1);
    tick();
    chk("bp first in_ready", 128'(in_if.ready), 128'(1));
    b.alu = 32'hB; put(b, 1'b1);
    tick();
    chk("bp full in_ready", 128'(in_if.ready), 128'(0));
    chk("bp hold A", 128'(out_if.alu_result), 128'(32'hA));
    put('0, 1'b0);
    tick();
    chk("bp still A", 128'(out_if.alu_result), 128'(32'hA));
    out_if.ready = 1'b1;
    tick();
    chk("bp then B", 128'(out_if.alu_result), 128'(32'hB));
    chk("bp in_ready back", 128'(in_if.ready), 128'(1));
    tick();
    chk("bp drained", 128'(out_if.valid), 128'(0));

    // Branch decisions.
    for (int i = 0; i < 4; i++) begin
      b = '0;
      b.br = bt[i].br; b.f3 = bt[i].f3; b.z = bt[i].z; b.alu = bt[i].alu;
      put(b, 1'b1);
      tick();
      chk("branch decision", 128'(out_br), 128'(bt[i].exp));
    end
    put('0, 1'b0);
    tick();

    // Flush while full, with another beat offered in the same cycle.
    out_if.ready = 1'b0;
    b = '0; b.alu = 32'h55; put(b, 1'b1); tick();
    b.alu = 32'h66; put(b, 1'b1); tick();
    chk("flush pre full", 128'(in_if.ready), 128'(0));
    flush = 1'b1;
    b.alu = 32'h77; put(b, 1'b1);
    tick();
    chk("flush out_valid", 128'(out_if.valid), 128'(0));
    chk("flush in_ready", 128'(in_if.ready), 128'(1));
    flush = 1'b0;
    put('0, 1'b0);
    out_if.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush no emit", 128'(out_if.valid), 128'(0));
    end

    // Stall counter: five stalled cycles after a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_if.ready = 1'b0;
    b = '0; b.alu = 32'h99; put(b, 1'b1);
    tick();
    put('0, 1'b0);
    repeat (5) tick();
`ifdef PERF_CNT_EN
    chk("stall five", 128'(stall), 128'(5));
`else
    chk("stall tied", 128'(stall), 128'(0));
`endif
    out_if.ready = 1'b1;
    tick();

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      put(rnd_beat(), 1'($urandom_range(0, 3) != 0));
      out_if.ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1'b1;
    flush = 1'b0;
    put('0, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
